keypad_debounce_decoder: RTL

- Consumes the rotating one-hot column strobe from the keypad column scanner plus the four active-low keypad row lines.
- Detects a pressed key and debounces press and release by counting consistent observations.
- Emits a 4-bit hex key code with a one-cycle valid pulse per debounced press.
- Sits between the scanner/keypad pins and the display/key-register logic; at most one registered key is reported at a time.

---
 rtl/keypad_pkg.sv | 56 +++++
 rtl/keypad_row_sync.sv | 34 +++
 rtl/keypad_debounce_decoder.sv | 166 ++++++++++++++++
 3 files changed

// File: rtl/keypad_pkg.sv
// Shared types and helpers for the keypad debounce decoder.
// Holds the debounce FSM state type, the row/column to hex code map,
// and small decode helpers for the column strobe and the row lines.
package keypad_pkg;

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DB,
        HELD,
        REL_DB
    } state_t;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } onehot_idx_t;

    // Indexed as KEY_MAP[row][col]
    localparam logic [3:0] KEY_MAP [4][4] = '{
        '{4'h1, 4'h2, 4'h3, 4'hA},
        '{4'h4, 4'h5, 4'h6, 4'hB},
        '{4'h7, 4'h8, 4'h9, 4'hC},
        '{4'hE, 4'h0, 4'hF, 4'hD}
    };

    // Column strobe to index; valid only when exactly one bit is set
    function automatic onehot_idx_t onehot_to_idx(input logic [3:0] vec);
        onehot_idx_t res;
        res.valid = 1'b1;
        res.idx   = 2'd0;
        case (vec)
            4'b0001: res.idx = 2'd0;
            4'b0010: res.idx = 2'd1;
            4'b0100: res.idx = 2'd2;
            4'b1000: res.idx = 2'd3;
            default: res.valid = 1'b0;
        endcase
        return res;
    endfunction

    // Lowest-numbered row that is pulled low wins when several are low
    function automatic logic [1:0] lowest_low_row(input logic [3:0] rows_n);
        logic [1:0] row;
        if (!rows_n[0]) begin
            row = 2'd0;
        end else if (!rows_n[1]) begin
            row = 2'd1;
        end else if (!rows_n[2]) begin
            row = 2'd2;
        end else begin
            row = 2'd3;
        end
        return row;
    endfunction

endpackage

// File: rtl/keypad_row_sync.sv
// Two-flop synchronizer for the asynchronous row lines, with the column
// strobe delayed through the same number of registers so every row sample
// stays paired with the column that was driving the keypad when it was taken.
// Only compiled when KEYPAD_ROW_SYNC_EN is defined.
`ifdef KEYPAD_ROW_SYNC_EN
module keypad_row_sync (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_in,
    input  logic [3:0] rows_n_in,
    output logic [3:0] col_out,
    output logic [3:0] rows_n_out
);

    logic [3:0] rows_meta;
    logic [3:0] col_meta;

    // Two-stage pipeline; rows idle high (no key) and columns idle at no strobe
    always_ff @(posedge clk) begin
        if (!reset) begin
            rows_meta  <= 4'hF;
            rows_n_out <= 4'hF;
            col_meta   <= 4'h0;
            col_out    <= 4'h0;
        end else begin
            rows_meta  <= rows_n_in;
            rows_n_out <= rows_meta;
            col_meta   <= col_in;
            col_out    <= col_meta;
        end
    end

endmodule
`endif

// File: rtl/keypad_debounce_decoder.sv
// Keypad debounce and decode. Watches the rotating one-hot column strobe
// and the active-low row lines, latches the first key seen, confirms press
// and release by counting consecutive consistent observations of that key,
// and reports a hex code with a one-cycle valid pulse per accepted press.
// Define KEYPAD_ROW_SYNC_EN to insert a two-flop row synchronizer (and a
// matching column delay) in front of the decoder.
module keypad_debounce_decoder
    import keypad_pkg::*;
#(
    parameter int DEBOUNCE_OBS = 8,
    parameter int CNT_W        = 8
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] col_onehot,
    input  logic [3:0] rows_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam logic [CNT_W-1:0] OBS_TARGET = CNT_W'(DEBOUNCE_OBS);
    localparam bit               ONE_OBS    = (DEBOUNCE_OBS <= 1);

    logic [3:0] obs_col;
    logic [3:0] obs_rows_n;

`ifdef KEYPAD_ROW_SYNC_EN
    keypad_row_sync u_row_sync (
        .clk        (clk),
        .reset      (reset),
        .col_in     (col_onehot),
        .rows_n_in  (rows_n),
        .col_out    (obs_col),
        .rows_n_out (obs_rows_n)
    );
`else
    assign obs_col    = col_onehot;
    assign obs_rows_n = rows_n;
`endif

    state_t           state, state_n;
    logic [CNT_W-1:0] cnt, cnt_n, cnt_inc;
    logic [1:0]       trk_col, trk_col_n;
    logic [1:0]       trk_row, trk_row_n;
    logic [3:0]       key_code_n;
    logic             key_valid_n;
    logic             key_held_n;

    onehot_idx_t      col_dec;
    logic             any_hit;
    logic [1:0]       hit_row;
    logic             trk_obs;
    logic             trk_low;

    // Decode the current observation and how it relates to the tracked key
    always_comb begin
        col_dec = onehot_to_idx(obs_col);
        any_hit = (obs_rows_n != 4'hF);
        hit_row = lowest_low_row(obs_rows_n);
        trk_obs = col_dec.valid && (col_dec.idx == trk_col);
        trk_low = !obs_rows_n[trk_row];
        cnt_inc = (cnt == {CNT_W{1'b1}}) ? cnt : cnt + 1'b1;
    end

    // Next-state and registered-output logic of the debounce FSM
    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        trk_col_n   = trk_col;
        trk_row_n   = trk_row;
        key_code_n  = key_code;
        key_valid_n = 1'b0;
        key_held_n  = key_held;
        case (state)
            IDLE: begin
                if (col_dec.valid && any_hit) begin
                    trk_col_n = col_dec.idx;
                    trk_row_n = hit_row;
                    if (ONE_OBS) begin
                        state_n     = HELD;
                        cnt_n       = '0;
                        key_code_n  = KEY_MAP[hit_row][col_dec.idx];
                        key_valid_n = 1'b1;
                        key_held_n  = 1'b1;
                    end else begin
                        state_n = PRESS_DB;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            PRESS_DB: begin
                if (trk_obs) begin
                    if (trk_low) begin
                        if (cnt_inc >= OBS_TARGET) begin
                            state_n     = HELD;
                            cnt_n       = '0;
                            key_code_n  = KEY_MAP[trk_row][trk_col];
                            key_valid_n = 1'b1;
                            key_held_n  = 1'b1;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = IDLE;
                        cnt_n   = '0;
                    end
                end
            end
            HELD: begin
                if (trk_obs && !trk_low) begin
                    if (ONE_OBS) begin
                        state_n    = IDLE;
                        cnt_n      = '0;
                        key_held_n = 1'b0;
                    end else begin
                        state_n = REL_DB;
                        cnt_n   = CNT_W'(1);
                    end
                end
            end
            REL_DB: begin
                if (trk_obs) begin
                    if (!trk_low) begin
                        if (cnt_inc >= OBS_TARGET) begin
                            state_n    = IDLE;
                            cnt_n      = '0;
                            key_held_n = 1'b0;
                        end else begin
                            cnt_n = cnt_inc;
                        end
                    end else begin
                        state_n = HELD;
                        cnt_n   = '0;
                    end
                end
            end
            default: begin
                state_n = IDLE;
                cnt_n   = '0;
            end
        endcase
    end

    // State, tracking and output registers; reset aborts any debounce in flight
    always_ff @(posedge clk) begin
        if (!reset) begin
            state     <= IDLE;
            cnt       <= '0;
            trk_col   <= 2'd0;
            trk_row   <= 2'd0;
            key_code  <= 4'h0;
            key_valid <= 1'b0;
            key_held  <= 1'b0;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            trk_col   <= trk_col_n;
            trk_row   <= trk_row_n;
            key_code  <= key_code_n;
            key_valid <= key_valid_n;
            key_held  <= key_held_n;
        end
    end

endmodule
